// File: rtl/apb_master_arbiter_if.sv
// Requester-side and APB-side signals of the APB master arbiter.
// The master modport faces the arbiter; the slave modport faces requesters and the APB slave.
interface apb_master_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // requester side
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_write;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            req_grant;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_rdata;
  logic                          busy;

  // APB side
  logic                          pselx;
  logic                          penable;
  logic                          pwrite;
  logic [ADDR_WIDTH-1:0]         paddr;
  logic [DATA_WIDTH-1:0]         pwdata;
  logic [DATA_WIDTH-1:0]         prdata;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, prdata,
    output req_grant, rsp_valid, rsp_rdata, busy,
           pselx, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, prdata,
    input  req_grant, rsp_valid, rsp_rdata, busy,
           pselx, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_master_arbiter.sv
// Round-robin requester arbiter driving a zero-wait-state APB master; SETUP one cycle after request, rsp_valid two cycles later.
// Requesters hold req_valid until granted; define APB_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module apb_master_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic                 clock_i,
  input logic                 reset_i,
  apb_master_arbiter_if.master bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       winner_q, winner_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic                   pselx_q, pselx_d;
  logic                   penable_q, penable_d;
  logic                   pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0]  paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0]  pwdata_q, pwdata_d;

  logic                   win_found;
  logic [IDX_W-1:0]       win_idx;
  logic                   win_write;
  logic [ADDR_WIDTH-1:0]  win_addr;
  logic [DATA_WIDTH-1:0]  win_wdata;
  logic                   take;

`ifdef APB_ARB_FIXED_PRIO_EN
  // Scan downward so the lowest requesting index is the last writer and wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(i);
      end
    end
  end
`else
  logic [IDX_W-1:0] last_grant_q, last_grant_d;
  logic [IDX_W-1:0] cand;

  // Search begins one past the previous winner and wraps.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last_grant_q) + k) % NUM_REQ);
      if (!win_found && bus.req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end
`endif

  assign win_write = bus.req_write[win_idx];
  assign win_addr  = bus.req_addr[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign win_wdata = bus.req_wdata[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    state_d     = state_q;
    winner_d    = winner_q;
    grant_d     = '0;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    pselx_d     = pselx_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    take        = 1'b0;
`ifndef APB_ARB_FIXED_PRIO_EN
    last_grant_d = last_grant_q;
`endif

    case (state_q)
      IDLE: begin
        take = win_found;
      end
      SETUP: begin
        state_d   = ACCESS;
        pselx_d   = 1'b1;
        penable_d = 1'b1;
      end
      ACCESS: begin
        rsp_valid_d = NUM_REQ'(1) << winner_q;
        if (!pwrite_q) begin
          rsp_rdata_d = bus.prdata;
        end
        if (win_found) begin
          take = 1'b1;
        end else begin
          state_d   = IDLE;
          pselx_d   = 1'b0;
          penable_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        pselx_d   = 1'b0;
        penable_d = 1'b0;
      end
    endcase

    // A new winner is loaded from IDLE or straight out of ACCESS, keeping pselx high.
    if (take) begin
      state_d   = SETUP;
      winner_d  = win_idx;
      grant_d   = NUM_REQ'(1) << win_idx;
      pselx_d   = 1'b1;
      penable_d = 1'b0;
      pwrite_d  = win_write;
      paddr_d   = win_addr;
      pwdata_d  = win_wdata;
`ifndef APB_ARB_FIXED_PRIO_EN
      last_grant_d = win_idx;
`endif
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      winner_q    <= '0;
      grant_q     <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      pselx_q     <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      winner_q    <= winner_d;
      grant_q     <= grant_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      pselx_q     <= pselx_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
    end
  end

`ifndef APB_ARB_FIXED_PRIO_EN
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      last_grant_q <= IDX_W'(NUM_REQ - 1);
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  assign bus.req_grant = grant_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.busy      = pselx_q;
  assign bus.pselx     = pselx_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed and randomized bench for apb_master_arbiter against a transaction-level reference model.
module tb_apb_master_arbiter;
  localparam int NR = 2;
  localparam int AW = 32;
  localparam int DW = 32;
`ifdef APB_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  apb_master_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bif ();

  apb_master_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (bif)
  );

  int total  = 0;
  int passed = 0;

  // Reference model: phase 0 = bus idle, 1 = setup, 2 = access.
  int            m_phase = 0;
  int            m_last  = NR - 1;
  int            m_win   = 0;
  logic          m_write = 1'b0;
  logic [AW-1:0] m_addr  = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] m_rdata = '0;
  logic [NR-1:0] e_grant = '0;
  logic [NR-1:0] e_rsp   = '0;

  bit pending [NR];
  int wait_cnt [NR];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int pick(input logic [NR-1:0] v, input int last);
    int w;
    w = -1;
    for (int k = 1; k <= NR; k++) begin
      int idx;
      idx = FIXED ? (k - 1) : ((last + k) % NR);
      if (w < 0 && v[idx]) w = idx;
    end
    return w;
  endfunction

  task automatic model_edge();
    int w;
    e_grant = '0;
    e_rsp   = '0;
    if (rst) begin
      m_phase = 0; m_last = NR - 1; m_write = 1'b0;
      m_addr = '0; m_wdata = '0; m_rdata = '0;
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else begin
      if (m_phase == 2) begin
        e_rsp[m_win] = 1'b1;
        if (!m_write) m_rdata = bif.prdata;
      end
      w = pick(bif.req_valid, m_last);
      if (w >= 0) begin
        m_phase = 1; m_win = w; m_last = w;
        m_write = bif.req_write[w];
        m_addr  = bif.req_addr[w*AW +: AW];
        m_wdata = bif.req_wdata[w*DW +: DW];
        e_grant[w] = 1'b1;
      end else begin
        m_phase = 0;
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("pselx",     bif.pselx,     m_phase != 0);
    check("penable",   bif.penable,   m_phase == 2);
    check("busy",      bif.busy,      m_phase != 0);
    check("req_grant", bif.req_grant, e_grant);
    check("rsp_valid", bif.rsp_valid, e_rsp);
    check("rsp_rdata", bif.rsp_rdata, m_rdata);
    check("pwrite",    bif.pwrite,    m_write);
    check("paddr",     bif.paddr,     m_addr);
    check("pwdata",    bif.pwdata,    m_wdata);
  endtask

  task automatic set_req(input int i, input logic v, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    bif.req_valid[i] = v;
    bif.req_write[i] = w;
    bif.req_addr[i*AW +: AW]  = a;
    bif.req_wdata[i*DW +: DW] = d;
  endtask

  initial begin
    bif.req_valid = '0;
    bif.req_write = '0;
    bif.req_addr  = '0;
    bif.req_wdata = '0;
    bif.prdata    = '0;
    rst = 1'b1;
    step();
    step();
    check("rst_pselx",     bif.pselx,     0);
    check("rst_rsp_rdata", bif.rsp_rdata, 0);
    check("rst_paddr",     bif.paddr,     0);
    rst = 1'b0;
    step();

    // single read from requester 0
    set_req(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
    step();
    check("rd_setup_grant",   bif.req_grant, 2'b01);
    check("rd_setup_paddr",   bif.paddr,     32'h10);
    check("rd_setup_pwrite",  bif.pwrite,    0);
    check("rd_setup_penable", bif.penable,   0);
    bif.req_valid[0] = 1'b0;
    bif.prdata = 32'hDEAD_BEEF;
    step();
    check("rd_access_penable", bif.penable, 1);
    step();
    check("rd_rsp_valid", bif.rsp_valid, 2'b01);
    check("rd_rsp_rdata", bif.rsp_rdata, 32'hDEAD_BEEF);
    check("rd_idle_pselx", bif.pselx, 0);

    // single write from requester 1
    set_req(1, 1'b1, 1'b1, 32'h0000_0024, 32'h1234_5678);
    step();
    check("wr_setup_grant",  bif.req_grant, 2'b10);
    check("wr_setup_pwdata", bif.pwdata,    32'h1234_5678);
    check("wr_setup_pwrite", bif.pwrite,    1);
    bif.req_valid[1] = 1'b0;
    bif.prdata = $urandom;
    step();
    check("wr_access_pwdata", bif.pwdata, 32'h1234_5678);
    check("wr_access_pwrite", bif.pwrite, 1);
    step();
    check("wr_rsp_valid", bif.rsp_valid, 2'b10);
    check("wr_rsp_rdata", bif.rsp_rdata, 32'hDEAD_BEEF);

    // contention: both held valid for four transfers
    set_req(0, 1'b1, 1'b0, $urandom, $urandom);
    set_req(1, 1'b1, 1'b1, $urandom, $urandom);
    for (int k = 1; k <= 8; k++) begin
      bif.prdata = $urandom;
      step();
      check("cont_pselx",   bif.pselx,   1);
      check("cont_penable", bif.penable, (k % 2) == 0);
      if (k % 2 == 1)
        check("cont_grant", bif.req_grant,
              FIXED ? 2'b01 : (((k / 2) % 2 == 1) ? 2'b10 : 2'b01));
    end
    bif.req_valid = '0;
    step();
    check("cont_last_rsp", bif.rsp_valid, FIXED ? 2'b01 : 2'b10);
    check("cont_end_pselx", bif.pselx, 0);

    // back-to-back reads from requester 0
    set_req(0, 1'b1, 1'b0, 32'h0000_0100, 32'h0);
    step();
    step();
    bif.prdata = 32'h1;
    step();
    check("b2b_rsp1_valid", bif.rsp_valid, 2'b01);
    check("b2b_rsp1_rdata", bif.rsp_rdata, 32'h1);
    check("b2b_grant2",     bif.req_grant, 2'b01);
    bif.req_valid[0] = 1'b0;
    step();
    check("b2b_gap_rsp", bif.rsp_valid, 2'b00);
    bif.prdata = 32'h2;
    step();
    check("b2b_rsp2_valid", bif.rsp_valid, 2'b01);
    check("b2b_rsp2_rdata", bif.rsp_rdata, 32'h2);

    // reset asserted during ACCESS
    set_req(1, 1'b1, 1'b0, $urandom, $urandom);
    step();
    bif.req_valid[1] = 1'b0;
    step();
    check("rstmid_in_access", bif.penable, 1);
    rst = 1'b1;
    step();
    check("rstmid_pselx",   bif.pselx,     0);
    check("rstmid_penable", bif.penable,   0);
    check("rstmid_busy",    bif.busy,      0);
    check("rstmid_rsp",     bif.rsp_valid, 0);
    rst = 1'b0;
    set_req(0, 1'b1, 1'b1, $urandom, $urandom);
    set_req(1, 1'b1, 1'b0, $urandom, $urandom);
    step();
    check("rstmid_first_grant", bif.req_grant, 2'b01);
    bif.req_valid[0] = 1'b0;
    pending[0] = 1'b0; wait_cnt[0] = 0;
    pending[1] = 1'b1; wait_cnt[1] = 1;

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!pending[i] && $urandom_range(0, 2) == 0) begin
          set_req(i, 1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom);
          pending[i] = 1'b1;
          wait_cnt[i] = 0;
        end
      end
      bif.prdata = $urandom;
      step();
      if (bif.req_grant != '0) begin
        for (int i = 0; i < NR; i++) begin
          if (pending[i] && bif.req_grant[i]) begin
            check("wait_bound", wait_cnt[i] <= (FIXED ? 100000 : NR - 1), 1);
            if ($urandom_range(0, 1) == 1) begin
              set_req(i, 1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom);
              wait_cnt[i] = 0;
            end else begin
              bif.req_valid[i] = 1'b0;
              pending[i] = 1'b0;
            end
          end else if (pending[i]) begin
            wait_cnt[i]++;
          end
        end
      end
    end

    bif.req_valid = '0;
    for (int k = 0; k < 4; k++) step();
    check("drain_pselx", bif.pselx, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/apb_master_arbiter.md
# apb_master_arbiter

Round-robin arbiter and APB master sequencer sitting on the APB side of the AHB-APB bridge. It accepts transfer requests from NUM_REQ independent requesters, such as the AHB slave-interface decoder and a debug/config port. It grants one requester at a time and drives the SETUP/ACCESS phases on the single-select APB bus. It returns read data and completion pulses to the originating requester.

## Interface
- NUM_REQ, 2, number of requesters (2..8)
- ADDR_WIDTH, 32, APB address width
- DATA_WIDTH, 32, APB data width

- clock  in  1  bus clock; all logic on posedge
- reset  in  1  synchronous, active-high
- req_valid  in  NUM_REQ  per-requester transfer request, level
- req_write  in  NUM_REQ  per-requester direction, 1 = write
- req_addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  NUM_REQ*DATA_WIDTH  flattened write data, same packing
- req_grant  out  NUM_REQ  one-hot, high for the SETUP cycle of the granted transfer
- rsp_valid  out  NUM_REQ  one-hot, one-cycle completion pulse
- rsp_rdata  out  DATA_WIDTH  read data for the completing read
- busy  out  1  high in SETUP or ACCESS
- pselx  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- paddr  out  ADDR_WIDTH  APB address
- pwdata  out  DATA_WIDTH  APB write data
- prdata  in  DATA_WIDTH  APB read data

## Operation
- FSM states: IDLE, SETUP, ACCESS. All outputs are registered.
- IDLE:
  - If any req_valid is high at the edge, the arbiter picks a winner, latches its write/addr/wdata, and enters SETUP.
  - Otherwise it stays in IDLE.
- SETUP: pselx=1, penable=0, req_grant[winner]=1. Always goes to ACCESS next.
- ACCESS: pselx=1, penable=1. The bus has no wait states, so ACCESS lasts exactly one cycle.
  - At the closing edge of ACCESS, prdata is captured for reads.
  - At the same edge, the arbiter re-evaluates req_valid. If any is high, the FSM goes to SETUP with the new winner and pselx stays 1. Otherwise it goes to IDLE.
- Arbitration is round-robin: search starts at index (last_grant+1) mod NUM_REQ. last_grant updates only on grant.
- Requester contract:
  - Fields are latched at arbitration, so a requester may change them once req_grant is seen.
  - A requester must drop or re-present req_valid at the edge ending its grant cycle. A req_valid still high during ACCESS is treated as a new request.
- Write completion: rsp_valid pulses and rsp_rdata is unchanged.
- Read completion: rsp_valid pulses and rsp_rdata takes the captured prdata. rsp_rdata holds its value until the next read completes.
- IDLE bus values: pselx=0, penable=0. paddr/pwrite/pwdata hold their last values. Only the SETUP/ACCESS values are significant.

## Timing
- Reset values: state IDLE; pselx, penable, pwrite, busy, req_grant, rsp_valid = 0; paddr, pwdata, rsp_rdata = 0; last_grant = NUM_REQ-1, so requester 0 wins first.
- req_valid high in cycle N while IDLE gives SETUP in N+1, ACCESS in N+2, and rsp_valid in N+3.
- Back-to-back transfers take 2 cycles each. With continuous requests, pselx never drops.
- A rsp_valid for transfer k and req_grant for transfer k+1 may be high in the same cycle.
- Reset asserted mid-transfer: the next cycle shows reset values. No rsp_valid is issued for the aborted transfer.
- A requester that becomes valid while another transfer is in flight is served at most NUM_REQ-1 grants later.

## Configuration
- APB_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins. last_grant is not implemented, and starvation of higher indices is permitted.
- Undefined (default): round-robin as described above.

## Test plan
- Single read: req_valid[0]=1, req_addr[0]=0x0000_0010, slave prdata=0xDEAD_BEEF.
  - SETUP at N+1 with paddr=0x10, pwrite=0.
  - ACCESS at N+2.
  - rsp_valid=2'b01 and rsp_rdata=0xDEAD_BEEF at N+3.
- Single write: req 1, addr 0x24, wdata 0x1234_5678.
  - pwdata=0x1234_5678 and pwrite=1 through SETUP/ACCESS.
  - rsp_valid=2'b10; rsp_rdata unchanged.
- Contention: both requesters held valid for 4 transfers.
  - Grants alternate 0,1,0,1.
  - pselx stays high for 8 cycles and penable toggles 0,1 each cycle.
- Back-to-back reads from requester 0, with prdata 0x1 then 0x2.
  - Two rsp_valid pulses 2 cycles apart carrying 0x1 then 0x2.
- Reset asserted during ACCESS.
  - Next cycle: pselx=0, penable=0, busy=0, no rsp_valid.
  - After release, requester 0 wins first.
- With APB_ARB_FIXED_PRIO_EN, both requesters valid continuously: requester 0 is granted every time and requester 1 is never granted.
